// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipeline register line.
package dff_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline slot: a valid bit plus its data word, with clear, load and hold.
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             v_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             v_out,
    output logic [WIDTH-1:0] data_out
);

    logic             v_d, v_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Clear drops only the valid bit; data is captured only alongside a valid word.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (clear) begin
            v_d = 1'b0;
        end else if (load) begin
            v_d = v_in;
            if (v_in) begin
                data_d = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_q    <= 1'b0;
            data_q <= RESET_VAL;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v_out    = v_q;
    assign data_out = data_q;

endmodule

// File: rtl/dff_pipeline.sv
// DEPTH-stage register pipeline with valid/ready at both ends, collapsing bubbles,
// synchronous flush and a registered occupancy count.
module dff_pipeline
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              d,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              q,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CNT_W = count_width(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dff_pipeline: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] acc;
    logic [WIDTH-1:0] data [DEPTH];
    logic             in_fire, out_fire;
    logic [CNT_W-1:0] count_d, count_q;

    // True when every stage from i up to the output end holds a word.
    function automatic logic tail_full(input logic [DEPTH-1:0] vv, input int i);
        logic [DEPTH-1:0] m;
        m = {DEPTH{1'b1}} << i;
        return (vv & m) == m;
    endfunction

    // Stage i can take a word unless it and everything ahead is full and stalled;
    // evaluated per stage so the chain has no bit-to-bit feedback.
    always_comb begin
        acc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            acc[i] = out_ready | ~tail_full(v, i);
        end
    end

    assign in_ready  = acc[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign q         = data[DEPTH-1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             v_src;
        logic [WIDTH-1:0] d_src;
        if (g == 0) begin : g_head
            assign v_src = in_valid;
            assign d_src = d;
        end else begin : g_body
            assign v_src = v[g-1];
            assign d_src = data[g-1];
        end
        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clear    (flush),
            .load     (acc[g]),
            .v_in     (v_src),
            .data_in  (d_src),
            .v_out    (v[g]),
            .data_out (data[g])
        );
    end

    always_comb begin
        count_d = count_q + CNT_W'(in_fire) - CNT_W'(out_fire);
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_dff_pipeline.sv
// Bench for dff_pipeline: a DEPTH=4/WIDTH=8 instance and a DEPTH=1/WIDTH=1 instance
// share stimulus and are compared against a word-position queue model.
module tb_dff_pipeline;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] d = 8'h00;

    logic       ir_a, ov_a, ir_b, ov_b;
    logic [7:0] q_a;
    logic [0:0] q_b;
    logic [2:0] cnt_a;
    logic [0:0] cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
        .d(d), .out_valid(ov_a), .out_ready(out_ready), .q(q_a), .count(cnt_a)
    );

    dff_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
        .d(d[0]), .out_valid(ov_b), .out_ready(out_ready), .q(q_b), .count(cnt_b)
    );

    // Reference model: each in-flight word with its stage position, oldest first.
    typedef struct {
        logic [7:0] data;
        int         pos;
    } ent_t;

    ent_t mq_a[$];
    ent_t mq_b[$];

    logic       exp_ov [2];
    logic       exp_ir [2];
    logic [7:0] exp_q  [2];
    int         exp_cnt[2];

    logic       act_ov [2];
    logic       act_ir [2];
    logic [7:0] act_q  [2];
    int         act_cnt[2];

    always_comb begin
        act_ov[0]  = ov_a;
        act_ov[1]  = ov_b;
        act_ir[0]  = ir_a;
        act_ir[1]  = ir_b;
        act_q[0]   = q_a;
        act_q[1]   = {7'b0, q_b};
        act_cnt[0] = int'(cnt_a);
        act_cnt[1] = int'(cnt_b);
    end

    // A word moves one stage unless every slot ahead of it is full and the
    // consumer is stalled; a word moving past the last stage has been delivered.
    task automatic model_step();
        ent_t m[$];
        ent_t nm[$];
        ent_t e;
        int   depth;
        int   n;
        bit   rdy;
        for (int s = 0; s < 2; s++) begin
            depth = (s == 1) ? 1 : 4;
            if (s == 1) m = mq_b; else m = mq_a;
            nm.delete();
            if (rst && !flush) begin
                n   = m.size();
                rdy = (n < depth) || out_ready;
                for (int j = 0; j < n; j++) begin
                    e = m[j];
                    if (out_ready || (j < depth - 1 - e.pos)) e.pos++;
                    if (e.pos < depth) nm.push_back(e);
                end
                if (in_valid && rdy) begin
                    e.data = (s == 1) ? {7'b0, d[0]} : d;
                    e.pos  = 0;
                    nm.push_back(e);
                end
            end
            if (s == 1) mq_b = nm; else mq_a = nm;
        end
    endtask

    task automatic expect_now();
        ent_t m[$];
        int   depth;
        int   n;
        for (int s = 0; s < 2; s++) begin
            depth = (s == 1) ? 1 : 4;
            if (s == 1) m = mq_b; else m = mq_a;
            n          = m.size();
            exp_cnt[s] = n;
            exp_ov[s]  = (n > 0) && (m[0].pos == depth - 1);
            exp_q[s]   = (n > 0) ? m[0].data : 8'h00;
            exp_ir[s]  = !flush && ((n < depth) || out_ready);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; d = 8'hAA; out_ready = 1'b0; flush = 1'b0;
        tick();
        tick();
        checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_ov_a got=%b want=0", ov_a); end
        checks++; if (q_a !== 8'h00) begin errors++; $display("FAIL reset_q_a got=%h want=00", q_a); end
        checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL reset_cnt_a got=%0d want=0", cnt_a); end
        checks++; if (ov_b !== 1'b0 || q_b !== 1'b0 || cnt_b !== 1'b0) begin
            errors++; $display("FAIL reset_b got ov=%b q=%b cnt=%b want 0/0/0", ov_b, q_b, cnt_b);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (ir_a !== 1'b1 || ir_b !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got a=%b b=%b want 1/1", ir_a, ir_b);
        end
    endtask

    task automatic test_latency();
        logic [7:0] sent[3];
        logic [7:0] got[$];
        int first_ov = -1;
        int peak = 0;
        sent[0] = 8'h11; sent[1] = 8'h22; sent[2] = 8'h33;
        out_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            in_valid = (t < 3);
            d = (t < 3) ? sent[t] : 8'h00;
            tick();
            in_valid = 1'b0;
            if (ov_a && first_ov < 0) first_ov = t;
            if (ov_a) got.push_back(q_a);
            if (int'(cnt_a) > peak) peak = int'(cnt_a);
        end
        checks++; if (first_ov != 3) begin errors++; $display("FAIL latency_first got=%0d want=3", first_ov); end
        checks++; if (got.size() != 3) begin
            errors++; $display("FAIL latency_count_out got=%0d want=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got[i] !== sent[i]) begin
                    errors++; $display("FAIL latency_word%0d got=%h want=%h", i, got[i], sent[i]);
                end
            end
        end
        checks++; if (peak != 3) begin errors++; $display("FAIL latency_peak got=%0d want=3", peak); end
        checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL latency_drain got=%0d want=0", cnt_a); end
    endtask

    task automatic test_stall_collapse();
        logic [7:0] want[4];
        want[0] = 8'hA1; want[1] = 8'hA2; want[2] = 8'hB1; want[3] = 8'hB2;
        out_ready = 1'b0;
        in_valid = 1'b1; d = want[0]; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; d = want[1]; tick();
        in_valid = 1'b0; tick(); tick(); tick();
        checks++; if (cnt_a !== 3'd2 || ov_a !== 1'b1 || q_a !== want[0]) begin
            errors++; $display("FAIL stall_pack got cnt=%0d ov=%b q=%h want 2/1/a1", cnt_a, ov_a, q_a);
        end
        in_valid = 1'b1; d = want[2]; tick();
        d = want[3]; tick();
        d = 8'hCC;
        #1;
        checks++; if (cnt_a !== 3'd4 || ir_a !== 1'b0) begin
            errors++; $display("FAIL stall_full got cnt=%0d in_ready=%b want 4/0", cnt_a, ir_a);
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ov_a !== 1'b1 || q_a !== want[i]) begin
                errors++; $display("FAIL stall_release%0d got ov=%b q=%h want 1/%h", i, ov_a, q_a, want[i]);
            end
            tick();
        end
        checks++; if (ov_a !== 1'b0 || cnt_a !== 3'd0) begin
            errors++; $display("FAIL stall_empty got ov=%b cnt=%0d want 0/0", ov_a, cnt_a);
        end
    endtask

    task automatic test_full_simultaneous();
        logic [7:0] want[$];
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; d = 8'hF0 + 8'(i); want.push_back(d);
            tick();
        end
        checks++; if (cnt_a !== 3'd4) begin errors++; $display("FAIL full_fill got=%0d want=4", cnt_a); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            #1;
            checks++; if (cnt_a !== 3'd4 || ov_a !== 1'b1 || ir_a !== 1'b1 || q_a !== want[i]) begin
                errors++; $display("FAIL full_stream%0d got cnt=%0d ov=%b ir=%b q=%h want 4/1/1/%h",
                                   i, cnt_a, ov_a, ir_a, q_a, want[i]);
            end
            want.push_back(d);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 10; i < 14; i++) begin
            checks++; if (ov_a !== 1'b1 || q_a !== want[i]) begin
                errors++; $display("FAIL full_drain%0d got ov=%b q=%h want 1/%h", i, ov_a, q_a, want[i]);
            end
            tick();
        end
        checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL full_end got=%0d want=0", cnt_a); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; d = 8'h50 + 8'(i);
            tick();
        end
        checks++; if (cnt_a !== 3'd3) begin errors++; $display("FAIL flush_pre got=%0d want=3", cnt_a); end
        flush = 1'b1; in_valid = 1'b1; d = 8'hEE;
        #1;
        checks++; if (ir_a !== 1'b0 || ir_b !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready got a=%b b=%b want 0/0", ir_a, ir_b);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (cnt_a !== 3'd0 || ov_a !== 1'b0) begin
            errors++; $display("FAIL flush_post got cnt=%0d ov=%b want 0/0", cnt_a, ov_a);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ov_a !== 1'b0 || ov_b !== 1'b0) begin
                errors++; $display("FAIL flush_quiet%0d got a=%b b=%b want 0/0", i, ov_a, ov_b);
            end
        end
    endtask

    task automatic test_midstream_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; d = 8'h71 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (cnt_a !== 3'd3 || cnt_b !== 1'b1) begin
            errors++; $display("FAIL midrst_pre got a=%0d b=%0d want 3/1", cnt_a, cnt_b);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (ov_a !== 1'b0 || cnt_a !== 3'd0 || q_a !== 8'h00) begin
            errors++; $display("FAIL midrst_a got ov=%b cnt=%0d q=%h want 0/0/00", ov_a, cnt_a, q_a);
        end
        checks++; if (ov_b !== 1'b0 || cnt_b !== 1'b0 || q_b !== 1'b0) begin
            errors++; $display("FAIL midrst_b got ov=%b cnt=%0d q=%b want 0/0/0", ov_b, cnt_b, q_b);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (ov_a !== 1'b0 || ov_b !== 1'b0) begin
                errors++; $display("FAIL midrst_quiet%0d got a=%b b=%b want 0/0", i, ov_a, ov_b);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 63) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            d         = 8'($urandom);
            #1;
            expect_now();
            for (int s = 0; s < 2; s++) begin
                checks++; if (act_ov[s] !== exp_ov[s]) begin
                    errors++; $display("FAIL rand_ov dut%0d cyc%0d got=%b want=%b", s, c, act_ov[s], exp_ov[s]);
                end
                checks++; if (act_ir[s] !== exp_ir[s]) begin
                    errors++; $display("FAIL rand_ir dut%0d cyc%0d got=%b want=%b", s, c, act_ir[s], exp_ir[s]);
                end
                checks++; if (act_cnt[s] != exp_cnt[s]) begin
                    errors++; $display("FAIL rand_cnt dut%0d cyc%0d got=%0d want=%0d", s, c, act_cnt[s], exp_cnt[s]);
                end
                if (exp_ov[s]) begin
                    checks++; if (act_q[s] !== exp_q[s]) begin
                        errors++; $display("FAIL rand_q dut%0d cyc%0d got=%h want=%h", s, c, act_q[s], exp_q[s]);
                    end
                end
            end
            tick();
        end
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_latency();
        test_stall_collapse();
        test_full_simultaneous();
        test_flush();
        test_midstream_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
